// File: rtl/halut_matmul_collector_if.sv
// Stream interface of the halut matmul output collector.
//   Input side : per-channel decoder result, valid strobe and local m address.
//   Output side: serialised result, global m address, source channel,
//                valid/ready handshake.
// Modports:
//   master - the collector (consumes decoder results, drives the stream)
//   slave  - the environment (drives decoder results, sinks the stream)
interface halut_matmul_collector_if #(
    parameter int NumCh        = 4,
    parameter int DecAddrWidth = 3,
    parameter int ResultWidth  = 32,
    parameter int MAddrWidth   = 5
);
    localparam int ChWidth = $clog2(NumCh);

    logic [ResultWidth-1:0]  result_i [NumCh];
    logic [NumCh-1:0]        valid_i;
    logic [DecAddrWidth-1:0] m_addr_i [NumCh];

    logic [ResultWidth-1:0]  result_o;
    logic [MAddrWidth-1:0]   m_addr_o;
    logic [ChWidth-1:0]      ch_o;
    logic                    valid_o;
    logic                    ready_i;

    modport master (
        input  result_i, valid_i, m_addr_i, ready_i,
        output result_o, m_addr_o, ch_o, valid_o
    );

    modport slave (
        output result_i, valid_i, m_addr_i, ready_i,
        input  result_o, m_addr_o, ch_o, valid_o
    );
endinterface

// File: rtl/halut_matmul_collector.sv
// Output collector for the halut matmul top.
// Buffers per-group decoder results in one small FIFO per channel and
// serialises them onto a single valid/ready stream carrying the global
// column address (local + ch*DecoderUnits).
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   flush_i        - synchronous clear of all buffered state and counters
//   bus            - collector_if.master: decoder inputs + output stream
//   overflow_o     - sticky, set when any input was dropped on a full FIFO
//   drop_cnt_o     - saturating count of dropped inputs
//   empty_o        - all FIFOs empty and no output pending
module halut_matmul_collector #(
    parameter int NumCh        = 4,
    parameter int DecoderUnits = 8,
    parameter int M            = 32,
    parameter int MAddrWidth   = $clog2(M),
    parameter int DecAddrWidth = $clog2(DecoderUnits),
    parameter int ResultWidth  = 32,
    parameter int FifoDepth    = 4,
    parameter int ArbMode      = 0,
    parameter int DropCntWidth = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    halut_matmul_collector_if.master bus,
    output logic                    overflow_o,
    output logic [DropCntWidth-1:0] drop_cnt_o,
    output logic                    empty_o
);
    localparam int ChWidth    = $clog2(NumCh);
    localparam int PtrWidth   = $clog2(FifoDepth);
    localparam int EntryWidth = ResultWidth + DecAddrWidth;
    localparam int SumWidth   = $clog2(NumCh + 1);

    logic [NumCh-1:0]      fifo_empty;
    logic [NumCh-1:0]      fifo_full;
    logic [NumCh-1:0]      push;
    logic [NumCh-1:0]      pop;
    logic [NumCh-1:0]      drop;
    logic [EntryWidth-1:0] head_data [NumCh];

    logic [ChWidth-1:0]    last_reg;
    logic [ChWidth-1:0]    grant_idx;
    logic [ChWidth-1:0]    cand;
    logic                  grant_valid;
    logic                  load;
    logic [EntryWidth-1:0] sel_entry;

    logic                    valid_reg;
    logic [ResultWidth-1:0]  result_reg;
    logic [MAddrWidth-1:0]   m_addr_reg;
    logic [ChWidth-1:0]      ch_reg;
    logic                    overflow_reg;
    logic [DropCntWidth-1:0] drop_cnt_reg;
    logic [DropCntWidth-1:0] drop_cnt_next;
    logic [SumWidth-1:0]     drop_sum;
    logic [DropCntWidth:0]   cnt_sum;

    // Output register may reload when it is free or being drained this cycle.
    assign load = grant_valid && (!valid_reg || bus.ready_i) && !flush_i;

    genvar gi;
    generate
        for (gi = 0; gi < NumCh; gi++) begin : g_ch
            logic [EntryWidth-1:0] mem [FifoDepth];
            // One extra pointer bit distinguishes full from empty.
            logic [PtrWidth:0]     wr_ptr_reg;
            logic [PtrWidth:0]     rd_ptr_reg;

            assign fifo_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
            assign fifo_full[gi]  = (wr_ptr_reg[PtrWidth] != rd_ptr_reg[PtrWidth]) &&
                                    (wr_ptr_reg[PtrWidth-1:0] == rd_ptr_reg[PtrWidth-1:0]);
            assign pop[gi]        = load && (grant_idx == ChWidth'(gi));
            // A full FIFO still accepts when its head leaves in the same cycle.
            assign push[gi]       = bus.valid_i[gi] && !flush_i && (!fifo_full[gi] || pop[gi]);
            assign drop[gi]       = bus.valid_i[gi] && !flush_i && fifo_full[gi] && !pop[gi];
            assign head_data[gi]  = mem[rd_ptr_reg[PtrWidth-1:0]];

            // When full and popping, the write slot equals the read slot; the
            // old head is captured by the output register on the same edge.
            always_ff @(posedge clk_i) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg[PtrWidth-1:0]] <= {bus.result_i[gi], bus.m_addr_i[gi]};
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else if (flush_i) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end
        end
    endgenerate

    // Arbiter: round-robin search starts after the last grant; fixed
    // priority searches from channel 0. NumCh is a power of two, so the
    // candidate index wraps naturally.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NumCh; k++) begin
            if (ArbMode == 0) cand = last_reg + ChWidth'(k + 1);
            else              cand = ChWidth'(k);
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign sel_entry = head_data[grant_idx];

    always_comb begin
        drop_sum = '0;
        for (int c = 0; c < NumCh; c++) begin
            drop_sum = drop_sum + SumWidth'(drop[c]);
        end
        cnt_sum       = {1'b0, drop_cnt_reg} + (DropCntWidth + 1)'(drop_sum);
        drop_cnt_next = cnt_sum[DropCntWidth] ? '1 : cnt_sum[DropCntWidth-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_reg    <= 1'b0;
            result_reg   <= '0;
            m_addr_reg   <= '0;
            ch_reg       <= '0;
            last_reg     <= ChWidth'(NumCh - 1);
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (flush_i) begin
            valid_reg    <= 1'b0;
            last_reg     <= ChWidth'(NumCh - 1);
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (load) begin
                valid_reg  <= 1'b1;
                result_reg <= sel_entry[EntryWidth-1:DecAddrWidth];
                m_addr_reg <= MAddrWidth'(sel_entry[DecAddrWidth-1:0]) +
                              MAddrWidth'(grant_idx) * MAddrWidth'(DecoderUnits);
                ch_reg     <= grant_idx;
                last_reg   <= grant_idx;
            end else if (valid_reg && bus.ready_i) begin
                valid_reg  <= 1'b0;
            end
            if (|drop) begin
                overflow_reg <= 1'b1;
                drop_cnt_reg <= drop_cnt_next;
            end
        end
    end

    assign bus.valid_o  = valid_reg;
    assign bus.result_o = result_reg;
    assign bus.m_addr_o = m_addr_reg;
    assign bus.ch_o     = ch_reg;
    assign overflow_o   = overflow_reg;
    assign drop_cnt_o   = drop_cnt_reg;
    assign empty_o      = (&fifo_empty) && !valid_reg;
endmodule

// File: tb/tb_halut_matmul_collector.sv
module tb_halut_matmul_collector;
    localparam int NCH   = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] r;
        logic [2:0]  a;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        ready;
    logic [3:0]  vin;
    logic [31:0] rin [NCH];
    logic [2:0]  ain [NCH];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    halut_matmul_collector_if #(.NumCh(4), .DecAddrWidth(3), .ResultWidth(32), .MAddrWidth(5)) bus0();
    halut_matmul_collector_if #(.NumCh(4), .DecAddrWidth(3), .ResultWidth(32), .MAddrWidth(5)) bus1();

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_drv
            assign bus0.result_i[gi] = rin[gi];
            assign bus1.result_i[gi] = rin[gi];
            assign bus0.m_addr_i[gi] = ain[gi];
            assign bus1.m_addr_i[gi] = ain[gi];
        end
    endgenerate
    assign bus0.valid_i = vin;
    assign bus1.valid_i = vin;
    assign bus0.ready_i = ready;
    assign bus1.ready_i = ready;

    logic       ovf0, ovf1, empty0, empty1;
    logic [7:0] drop0, drop1;

    halut_matmul_collector #(.ArbMode(0)) dut_rr (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus0),
        .overflow_o(ovf0), .drop_cnt_o(drop0), .empty_o(empty0)
    );
    halut_matmul_collector #(.ArbMode(1)) dut_fp (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus1),
        .overflow_o(ovf1), .drop_cnt_o(drop1), .empty_o(empty1)
    );

    // Index 0 = round-robin instance, 1 = fixed-priority instance.
    logic        o_valid [2];
    logic [31:0] o_result[2];
    logic [4:0]  o_addr  [2];
    logic [1:0]  o_ch    [2];
    logic        o_ovf   [2];
    logic [7:0]  o_drop  [2];
    logic        o_empty [2];
    assign o_valid[0] = bus0.valid_o;  assign o_valid[1] = bus1.valid_o;
    assign o_result[0] = bus0.result_o; assign o_result[1] = bus1.result_o;
    assign o_addr[0] = bus0.m_addr_o;  assign o_addr[1] = bus1.m_addr_o;
    assign o_ch[0] = bus0.ch_o;        assign o_ch[1] = bus1.ch_o;
    assign o_ovf[0] = ovf0;            assign o_ovf[1] = ovf1;
    assign o_drop[0] = drop0;          assign o_drop[1] = drop1;
    assign o_empty[0] = empty0;        assign o_empty[1] = empty1;

    // ---------------- behavioural reference model ----------------
    ent_t        mq [2][NCH][$];
    logic        mv [2];
    logic [31:0] mr [2];
    logic [4:0]  ma [2];
    logic [1:0]  mc [2];
    logic        movf [2];
    logic [7:0]  mdrop [2];
    int          mlast [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NCH; c++) mq[m][c].delete();
            mv[m] = 1'b0; mr[m] = '0; ma[m] = '0; mc[m] = '0;
            movf[m] = 1'b0; mdrop[m] = '0; mlast[m] = NCH - 1;
        end
    endtask

    function automatic bit m_empty(int m);
        bit e;
        e = !mv[m];
        for (int c = 0; c < NCH; c++) if (mq[m][c].size() != 0) e = 1'b0;
        return e;
    endfunction

    // Advance the model by one clock using the inputs presented now.
    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            int   sz [NCH];
            int   gch;
            bit   any;
            bit   ld;
            ent_t e;
            if (flush) begin
                for (int c = 0; c < NCH; c++) mq[m][c].delete();
                mv[m] = 1'b0; movf[m] = 1'b0; mdrop[m] = '0; mlast[m] = NCH - 1;
                continue;
            end
            any = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                sz[c] = mq[m][c].size();
                if (sz[c] > 0) any = 1'b1;
            end
            ld  = any && (!mv[m] || ready);
            gch = -1;
            if (ld) begin
                for (int k = 0; k < NCH; k++) begin
                    int c;
                    c = (m == 0) ? (mlast[m] + 1 + k) % NCH : k;
                    if (gch < 0 && sz[c] > 0) gch = c;
                end
                e = mq[m][gch].pop_front();
                mv[m] = 1'b1; mr[m] = e.r;
                ma[m] = 5'(int'(e.a) + 8 * gch);
                mc[m] = 2'(gch);
                mlast[m] = gch;
            end else if (mv[m] && ready) begin
                mv[m] = 1'b0;
            end
            for (int c = 0; c < NCH; c++) begin
                if (vin[c]) begin
                    if (sz[c] == DEPTH && gch != c) begin
                        movf[m] = 1'b1;
                        if (mdrop[m] != 8'hFF) mdrop[m] = mdrop[m] + 8'd1;
                    end else begin
                        e = {rin[c], ain[c]};
                        mq[m][c].push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        vin = '0; flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; ready = 1'b0; vin = '0;
        for (int c = 0; c < NCH; c++) begin rin[c] = '0; ain[c] = '0; end
        model_reset();
        #12;
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if ({o_valid[m], o_result[m], o_addr[m], o_ch[m], o_ovf[m], o_drop[m], o_empty[m]} !==
                {1'b0, 32'h0, 5'h0, 2'h0, 1'b0, 8'h0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset dut%0d: got v=%b r=%h a=%0d ch=%0d ovf=%b drop=%0d empty=%b, want all zero with empty=1",
                         m, o_valid[m], o_result[m], o_addr[m], o_ch[m], o_ovf[m], o_drop[m], o_empty[m]);
            end
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset: checked both instances");
    endtask

    task automatic test_single_push();
        ready = 1'b1;
        vin = 4'b0100; rin[2] = 32'h3F80_0000; ain[2] = 3'd5;
        step();
        vin = '0;
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if (o_valid[m] !== 1'b0) begin
                n_fail++;
                $display("FAIL single_t1 dut%0d: valid_o=%b, want 0 one cycle after push", m, o_valid[m]);
            end
        end
        step();
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if ({o_valid[m], o_result[m], o_addr[m], o_ch[m]} !== {1'b1, 32'h3F80_0000, 5'd21, 2'd2}) begin
                n_fail++;
                $display("FAIL single_out dut%0d: got v=%b r=%h a=%0d ch=%0d, want v=1 r=3f800000 a=21 ch=2",
                         m, o_valid[m], o_result[m], o_addr[m], o_ch[m]);
            end
        end
        step();
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if ({o_valid[m], o_empty[m]} !== 2'b01) begin
                n_fail++;
                $display("FAIL single_after dut%0d: valid_o=%b empty_o=%b, want 0/1", m, o_valid[m], o_empty[m]);
            end
        end
        $display("single_push: ch2 addr5 -> global 21");
    endtask

    task automatic test_rr_fairness();
        logic [31:0] pr [3][NCH];
        logic [2:0]  pa [3][NCH];
        int got;
        do_flush();
        ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc < 3) begin
                for (int c = 0; c < NCH; c++) begin
                    rin[c] = $urandom; ain[c] = 3'($urandom_range(0, 7));
                    pr[cyc][c] = rin[c]; pa[cyc][c] = ain[c];
                end
                vin = 4'hF;
            end else begin
                vin = '0;
            end
            step();
            if (o_valid[0] === 1'b1) begin
                int ech;
                ech = got % NCH;
                n_checks++;
                if (got >= 12) begin
                    n_fail++;
                    $display("FAIL rr_extra: unexpected output #%0d ch=%0d", got, o_ch[0]);
                end else if ({o_ch[0], o_result[0], o_addr[0]} !==
                             {2'(ech), pr[got / NCH][ech], 5'(int'(pa[got / NCH][ech]) + 8 * ech)}) begin
                    n_fail++;
                    $display("FAIL rr_out%0d: got ch=%0d r=%h a=%0d, want ch=%0d r=%h a=%0d", got,
                             o_ch[0], o_result[0], o_addr[0], ech, pr[got / NCH][ech],
                             int'(pa[got / NCH][ech]) + 8 * ech);
                end
                got++;
            end
        end
        n_checks++;
        if (got != 12 || o_drop[0] !== 8'd0 || o_ovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_count: outputs=%0d drop=%0d ovf=%b, want 12/0/0", got, o_drop[0], o_ovf[0]);
        end
        $display("rr_fairness: %0d outputs", got);
    endtask

    task automatic test_fixed_priority();
        logic [31:0] a0, a1, b3;
        logic [31:0] er [3];
        logic [1:0]  ec [3];
        int got;
        do_flush();
        ready = 1'b1;
        a0 = $urandom; a1 = $urandom; b3 = $urandom;
        er[0] = a0; er[1] = a1; er[2] = b3;
        ec[0] = 2'd0; ec[1] = 2'd0; ec[2] = 2'd3;
        got = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            vin = '0;
            if (cyc == 0) begin vin = 4'b1001; rin[0] = a0; ain[0] = 3'd1; rin[3] = b3; ain[3] = 3'd1; end
            if (cyc == 1) begin vin = 4'b0001; rin[0] = a1; ain[0] = 3'd1; end
            step();
            if (o_valid[1] === 1'b1) begin
                n_checks++;
                if (got >= 3) begin
                    n_fail++;
                    $display("FAIL fp_extra: unexpected output ch=%0d", o_ch[1]);
                end else if ({o_ch[1], o_result[1], o_addr[1]} !==
                             {ec[got], er[got], 5'(1 + 8 * int'(ec[got]))}) begin
                    n_fail++;
                    $display("FAIL fp_out%0d: got ch=%0d r=%h a=%0d, want ch=%0d r=%h a=%0d", got,
                             o_ch[1], o_result[1], o_addr[1], ec[got], er[got], 1 + 8 * int'(ec[got]));
                end
                got++;
            end
        end
        n_checks++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL fp_count: outputs=%0d, want 3", got);
        end
        $display("fixed_priority: %0d outputs", got);
    endtask

    task automatic test_backpressure();
        logic [31:0] e [7];
        int got;
        do_flush();
        ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            e[k] = $urandom;
            vin = 4'b0010; rin[1] = e[k]; ain[1] = 3'(k);
            step();
        end
        vin = '0;
        n_checks++;
        if ({o_valid[0], o_result[0], o_ovf[0], o_drop[0]} !== {1'b1, e[0], 1'b1, 8'd2}) begin
            n_fail++;
            $display("FAIL bp_overflow: got v=%b r=%h ovf=%b drop=%0d, want v=1 r=%h ovf=1 drop=2",
                     o_valid[0], o_result[0], o_ovf[0], o_drop[0], e[0]);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if ({o_valid[0], o_result[0], o_addr[0], o_ch[0]} !== {1'b1, e[0], 5'd8, 2'd1}) begin
                n_fail++;
                $display("FAIL bp_stall%0d: got v=%b r=%h a=%0d ch=%0d, want held v=1 r=%h a=8 ch=1",
                         k, o_valid[0], o_result[0], o_addr[0], o_ch[0], e[0]);
            end
        end
        ready = 1'b1;
        got = 0;
        // The entry already in the output register is accepted at the first edge.
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (o_valid[0] === 1'b1) begin
                n_checks++;
                if (got >= 5) begin
                    n_fail++;
                    $display("FAIL bp_extra: unexpected output r=%h", o_result[0]);
                end else if ({o_result[0], o_addr[0]} !== {e[got], 5'(8 + got)}) begin
                    n_fail++;
                    $display("FAIL bp_drain%0d: got r=%h a=%0d, want r=%h a=%0d",
                             got, o_result[0], o_addr[0], e[got], 8 + got);
                end
                got++;
            end
            step();
        end
        n_checks++;
        if (got != 5) begin
            n_fail++;
            $display("FAIL bp_count: outputs=%0d, want 5", got);
        end
        $display("backpressure: drained %0d entries", got);
    endtask

    task automatic test_full_pop();
        logic [31:0] e [6];
        int got;
        do_flush();
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            e[k] = $urandom;
            vin = 4'b0001; rin[0] = e[k]; ain[0] = 3'(k);
            step();
        end
        e[5] = $urandom;
        ready = 1'b1; vin = 4'b0001; rin[0] = e[5]; ain[0] = 3'd5;
        step();
        vin = '0;
        n_checks++;
        if ({o_drop[0], o_ovf[0], o_valid[0], o_result[0]} !== {8'd0, 1'b0, 1'b1, e[1]}) begin
            n_fail++;
            $display("FAIL fullpop_nodrop: got drop=%0d ovf=%b v=%b r=%h, want drop=0 ovf=0 v=1 r=%h",
                     o_drop[0], o_ovf[0], o_valid[0], o_result[0], e[1]);
        end
        got = 1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            step();
            if (o_valid[0] === 1'b1) begin
                got++;
                n_checks++;
                if (got > 5) begin
                    n_fail++;
                    $display("FAIL fullpop_extra: unexpected output r=%h", o_result[0]);
                end else if (o_result[0] !== e[got]) begin
                    n_fail++;
                    $display("FAIL fullpop_drain%0d: got r=%h, want r=%h", got, o_result[0], e[got]);
                end
            end
        end
        n_checks++;
        if (got != 5) begin
            n_fail++;
            $display("FAIL fullpop_count: last index=%0d, want 5", got);
        end
        $display("full_pop: drained through e%0d", got);
    endtask

    task automatic test_flush();
        do_flush();
        ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            vin = (k == 0) ? 4'b1100 : 4'b0100;
            rin[2] = $urandom; ain[2] = 3'(k); rin[3] = $urandom; ain[3] = 3'd0;
            step();
        end
        flush = 1'b1; vin = 4'b0001; rin[0] = $urandom; ain[0] = 3'd2;
        step();
        flush = 1'b0; vin = '0;
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if ({o_valid[m], o_empty[m], o_drop[m], o_ovf[m]} !== {1'b0, 1'b1, 8'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL flush dut%0d: got v=%b empty=%b drop=%0d ovf=%b, want 0/1/0/0",
                         m, o_valid[m], o_empty[m], o_drop[m], o_ovf[m]);
            end
        end
        ready = 1'b1;
        step(); step(); step();
        n_checks++;
        if ({o_valid[0], o_empty[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_discard: v=%b empty=%b, want 0/1 (flush-cycle input must vanish)",
                     o_valid[0], o_empty[0]);
        end
        $display("flush: state cleared");
    endtask

    task automatic test_reset_midstream();
        ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vin = 4'b0110; rin[1] = $urandom; rin[2] = $urandom; ain[1] = 3'(k); ain[2] = 3'(k);
            step();
        end
        vin = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if ({o_valid[m], o_result[m], o_addr[m], o_ch[m], o_ovf[m], o_drop[m], o_empty[m]} !==
                {1'b0, 32'h0, 5'h0, 2'h0, 1'b0, 8'h0, 1'b1}) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got v=%b r=%h a=%0d ch=%0d ovf=%b drop=%0d empty=%b, want reset values",
                         m, o_valid[m], o_result[m], o_addr[m], o_ch[m], o_ovf[m], o_drop[m], o_empty[m]);
            end
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset_midstream: outputs cleared without a clock edge");
    endtask

    task automatic test_drop_saturation();
        do_flush();
        ready = 1'b0;
        for (int k = 0; k < 80; k++) begin
            vin = 4'hF;
            for (int c = 0; c < NCH; c++) begin rin[c] = $urandom; ain[c] = 3'($urandom_range(0, 7)); end
            step();
        end
        vin = '0;
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if ({o_drop[m], o_ovf[m]} !== {8'hFF, 1'b1} || o_drop[m] !== mdrop[m]) begin
                n_fail++;
                $display("FAIL drop_sat dut%0d: drop=%0d ovf=%b, want 255/1", m, o_drop[m], o_ovf[m]);
            end
        end
        $display("drop_saturation: counter pinned at %0d", o_drop[0]);
    endtask

    task automatic test_random();
        int errs;
        do_flush();
        errs = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            vin = 4'($urandom);
            for (int c = 0; c < NCH; c++) begin rin[c] = $urandom; ain[c] = 3'($urandom_range(0, 7)); end
            ready = (cyc < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 49) == 0);
            step();
            for (int m = 0; m < 2; m++) begin
                n_checks++;
                if (o_valid[m] !== mv[m] || o_ovf[m] !== movf[m] || o_drop[m] !== mdrop[m] ||
                    o_empty[m] !== m_empty(m) ||
                    (mv[m] && {o_result[m], o_addr[m], o_ch[m]} !== {mr[m], ma[m], mc[m]})) begin
                    n_fail++; errs++;
                    $display("FAIL random dut%0d cyc%0d: got v=%b r=%h a=%0d ch=%0d ovf=%b drop=%0d empty=%b, want v=%b r=%h a=%0d ch=%0d ovf=%b drop=%0d empty=%b",
                             m, cyc, o_valid[m], o_result[m], o_addr[m], o_ch[m], o_ovf[m], o_drop[m], o_empty[m],
                             mv[m], mr[m], ma[m], mc[m], movf[m], mdrop[m], m_empty(m));
                end
            end
        end
        flush = 1'b0; vin = '0;
        $display("random: 400 cycles, %0d discrepancies", errs);
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_rr_fairness();
        test_fixed_priority();
        test_backpressure();
        test_full_pop();
        test_flush();
        test_reset_midstream();
        test_drop_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
